// File: rtl/sensor_packet_rx_if.sv
// Purpose : bundles the SPI pins and the packet/status outputs of sensor_packet_rx.
// Latency : none (wires only).
// Backpressure: none; SPI is push-only and outputs are level/pulse signals.
// Ports   : master = SPI driver side (drives cs_n/sck/sdi, observes results),
//           slave  = receiver side (samples cs_n/sck/sdi, drives results).
interface sensor_packet_rx_if #(
  parameter int NUM_WORDS = 6,
  parameter int CNT_W     = 8
);
  logic                   cs_n;
  logic                   sck;
  logic                   sdi;
  logic [16*NUM_WORDS-1:0] pkt_words;
  logic [7:0]             pkt_flags;
  logic                   pkt_valid;
  logic                   link_up;
  logic                   busy;
  logic [CNT_W-1:0]       hdr_err_cnt;
  logic [CNT_W-1:0]       len_err_cnt;
  logic [CNT_W-1:0]       csum_err_cnt;

  modport master (
    output cs_n, sck, sdi,
    input  pkt_words, pkt_flags, pkt_valid, link_up, busy,
    input  hdr_err_cnt, len_err_cnt, csum_err_cnt
  );

  modport slave (
    input  cs_n, sck, sdi,
    output pkt_words, pkt_flags, pkt_valid, link_up, busy,
    output hdr_err_cnt, len_err_cnt, csum_err_cnt
  );
endinterface

// File: rtl/sensor_packet_rx.sv
// Purpose : oversampled SPI mode-0 receive slave; validates header/length/XOR checksum and
//           commits good payloads atomically, with saturating error counters and link health.
// Latency : pkt_valid pulses SYNC_STAGES+2 clk cycles after the raw cs_n rising edge.
// Backpressure: none; the sender cannot be stalled, results are presented as a 1-cycle pulse.
// Ports   : clk, rst_n (async active-low); bus = sensor_packet_rx_if.slave carrying
//           cs_n/sck/sdi in and pkt_words/pkt_flags/pkt_valid/link_up/busy/err counters out.
module sensor_packet_rx #(
  parameter int          NUM_WORDS   = 6,
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 8,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  sensor_packet_rx_if.slave bus
);

  localparam int PKT_BYTES = 2*NUM_WORDS + 3;
  localparam int PL_BYTES  = 2*NUM_WORDS + 1;          // payload words + flags byte
  localparam int IDX_W     = $clog2(PKT_BYTES + 2);
  localparam int TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PKT_BYTES);
  localparam logic [IDX_W-1:0] IDX_OVF  = IDX_W'(PKT_BYTES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RX, EVAL} state_t;

  // Synchronizers reset to 0 so cs_n reads "asserted" until the real pin level
  // has propagated; this keeps WAIT_IDLE from releasing into a packet in flight.
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sdi_sync_q;
  logic                   cs_dly_q, sck_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '0;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_dly_q   <= 1'b0;
      sck_dly_q  <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0],  bus.cs_n};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
      cs_dly_q   <= cs_sync_q[SYNC_STAGES-1];
      sck_dly_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  logic cs_s, sdi_s, cs_rise, cs_fall, sck_rise;
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;
  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;

  state_t                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [6:0]              shift_q, shift_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]              csum_q, csum_d;
  logic                    hdr_bad_q, hdr_bad_d;
  logic [8*PL_BYTES-1:0]   pl_q, pl_d;
  logic [16*NUM_WORDS-1:0] words_q, words_d;
  logic [7:0]              flags_q, flags_d;
  logic                    valid_q, valid_d;
  logic                    link_q, link_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [CNT_W-1:0]        hdr_cnt_q, hdr_cnt_d, len_cnt_q, len_cnt_d, csum_cnt_q, csum_cnt_d;
  logic [7:0]              byte_now;

  assign byte_now = {shift_q, sdi_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    hdr_bad_d  = hdr_bad_q;
    pl_d       = pl_q;
    words_d    = words_q;
    flags_d    = flags_q;
    valid_d    = 1'b0;
    link_d     = link_q;
    tmo_d      = tmo_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_cnt_d  = len_cnt_q;
    csum_cnt_d = csum_cnt_q;

    // Link watchdog; a good packet below overrides an expiry in the same cycle.
    if (link_q) begin
      if (tmo_q == TMO_LAST) link_d = 1'b0;
      else                   tmo_d  = tmo_q + TMO_W'(1);
    end

    case (state_q)
      WAIT_IDLE: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          hdr_bad_d  = 1'b0;
          state_d    = RX;
        end
      end
      RX: begin
        if (sck_rise) begin
          shift_d   = {shift_q[5:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_idx_q == '0) hdr_bad_d = (byte_now != HEADER);
            // The checksum byte itself is folded in too: a good packet XORs to zero.
            if (byte_idx_q < IDX_FULL) csum_d = csum_q ^ byte_now;
            for (int j = 0; j < PL_BYTES; j++) begin
              if (byte_idx_q == IDX_W'(j + 1)) pl_d[8*j +: 8] = byte_now;
            end
            if (byte_idx_q != IDX_OVF) byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
        if (cs_rise) state_d = EVAL;
      end
      EVAL: begin
        state_d = IDLE;
        if (byte_idx_q == '0 && bit_cnt_q == '0) begin
          // CS glitch with no data: no outcome.
        end else if (hdr_bad_q) begin
          if (hdr_cnt_q != '1) hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
          link_d = 1'b0;
        end else if (bit_cnt_q != '0 || byte_idx_q != IDX_FULL) begin
          if (len_cnt_q != '1) len_cnt_d = len_cnt_q + CNT_W'(1);
          link_d = 1'b0;
        end else if (csum_q != 8'h00) begin
          if (csum_cnt_q != '1) csum_cnt_d = csum_cnt_q + CNT_W'(1);
          link_d = 1'b0;
        end else begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            words_d[16*k +: 16] = {pl_q[16*k +: 8], pl_q[16*k+8 +: 8]};
          end
          flags_d = pl_q[8*(PL_BYTES-1) +: 8];
          valid_d = 1'b1;
          link_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      hdr_bad_q  <= 1'b0;
      pl_q       <= '0;
      words_q    <= '0;
      flags_q    <= '0;
      valid_q    <= 1'b0;
      link_q     <= 1'b0;
      tmo_q      <= '0;
      hdr_cnt_q  <= '0;
      len_cnt_q  <= '0;
      csum_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      hdr_bad_q  <= hdr_bad_d;
      pl_q       <= pl_d;
      words_q    <= words_d;
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      link_q     <= link_d;
      tmo_q      <= tmo_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_cnt_q  <= len_cnt_d;
      csum_cnt_q <= csum_cnt_d;
    end
  end

  assign bus.pkt_words    = words_q;
  assign bus.pkt_flags    = flags_q;
  assign bus.pkt_valid    = valid_q;
  assign bus.link_up      = link_q;
  assign bus.busy         = (state_q == RX);
  assign bus.hdr_err_cnt  = hdr_cnt_q;
  assign bus.len_err_cnt  = len_cnt_q;
  assign bus.csum_err_cnt = csum_cnt_q;

endmodule
